// File: rtl/bus_endpoint_pkg.sv
// Shared types and helpers for the bus FIFO endpoint.
// Holds destination-ID layout, broadcast ID and a saturating counter type.
package bus_endpoint_pkg;

  localparam int         ID_MSB_OFS   = 8;
  localparam logic [7:0] BROADCAST_ID = 8'hFF;
  localparam int         MAX_PKT      = 1024;

  typedef logic [7:0] sat8_t;

  function automatic sat8_t sat_inc(input sat8_t c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Packets are zero-extended to MAX_PKT; sz is the real packet width.
  function automatic logic [ID_MSB_OFS-1:0] get_dest_id(
    input logic [MAX_PKT-1:0] pkt,
    input int                 sz
  );
    return pkt[sz-1 -: ID_MSB_OFS];
  endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count.
// Ports: wr_en/wr_data in, rd_en in, head/count/full/empty out.
module ep_sync_fifo #(
  parameter  int width = 32,
  parameter  int depth = 16,
  localparam int AW    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_rd;
  logic             do_wr;

  assign full  = (count_q == (AW+1)'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rptr_q];

  // A read frees the slot being written, so a full FIFO still accepts
  // a write in the same cycle as a read.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_fifo_endpoint.sv
// Device-side bus terminal: TX FIFO popped by the bus, RX FIFO fed by it.
// Ports: bus pndng/D_pop/pop/push/D_push, host wr/rd side, status counters.
module bus_fifo_endpoint
  import bus_endpoint_pkg::*;
#(
  parameter int         pckg_sz = 32,
  parameter int         depth   = 16,
  parameter logic [7:0] my_id   = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rd_valid,
  output logic               rx_empty,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         misdir_cnt,
  output logic               err_pop
);

  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0]      tx_count;
  logic               tx_empty;
  logic [CW-1:0]      rx_count;
  logic               rx_full;
  logic [pckg_sz-1:0] rx_head;

  logic               rd_ok;
  logic               rx_store;
  logic               rx_drop;
  logic               misdir;
  logic [7:0]         dest;

  sat8_t              drop_q;
  sat8_t              misdir_q;
  logic               err_pop_q;
  logic [pckg_sz-1:0] rd_data_q;
  logic               rd_valid_q;

  ep_sync_fifo #(
    .width(pckg_sz),
    .depth(depth)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .head   (D_pop),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  ep_sync_fifo #(
    .width(pckg_sz),
    .depth(depth)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_data(D_push),
    .rd_en  (rd_en),
    .head   (rx_head),
    .count  (rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  assign pndng = (tx_count != '0);

  // Mirrors the FIFO's own accept rules so the counters agree with it.
  assign rd_ok    = rd_en & ~rx_empty;
  assign rx_store = push & ((rx_count < CW'(depth)) | rd_ok);
  assign rx_drop  = push & rx_full & ~rd_ok;

  assign dest   = get_dest_id(MAX_PKT'(D_push), pckg_sz);
  assign misdir = rx_store & (dest != my_id) & (dest != BROADCAST_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q     <= '0;
      misdir_q   <= '0;
      err_pop_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rx_drop)         drop_q    <= sat_inc(drop_q);
      if (misdir)          misdir_q  <= sat_inc(misdir_q);
      if (pop && tx_empty) err_pop_q <= 1'b1;
      if (rd_ok)           rd_data_q <= rx_head;
      rd_valid_q <= rd_ok;
    end
  end

  assign drop_cnt   = drop_q;
  assign misdir_cnt = misdir_q;
  assign err_pop    = err_pop_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_bus_fifo_endpoint.sv
// Scoreboard bench for bus_fifo_endpoint with a queue-based reference model.
// Driver updates the model and pushes expectations; negedge monitor checks.
module tb_bus_fifo_endpoint;

  localparam int         W  = 32;
  localparam int         D  = 16;
  localparam logic [7:0] ID = 8'h02;

  typedef logic [31:0] word_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         pop = 1'b0;
  logic         push = 1'b0;
  logic [W-1:0] D_push = '0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         tx_full;
  logic         rd_en = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rx_empty;
  logic [7:0]   drop_cnt;
  logic [7:0]   misdir_cnt;
  logic         err_pop;

  always #5 clk = ~clk;

  bus_fifo_endpoint #(
    .pckg_sz(W),
    .depth  (D),
    .my_id  (ID)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .pop       (pop),
    .push      (push),
    .D_push    (D_push),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx_full   (tx_full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rx_empty  (rx_empty),
    .drop_cnt  (drop_cnt),
    .misdir_cnt(misdir_cnt),
    .err_pop   (err_pop)
  );

  // Reference model: FIFO contents as queues, counters as ints.
  word_t tq[$];
  word_t rq[$];
  word_t txexp[$];
  word_t rdexp[$];
  int    drop_m = 0;
  int    mis_m = 0;
  bit    err_m = 0;
  bit    rdv_next = 0;
  word_t rdd_next = '0;

  // Expected DUT state during the current cycle.
  bit    e_pndng, e_full, e_rxe, e_err, e_rdv;
  int    e_drop, e_mis;
  word_t e_rdd;

  bit chk_en = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit w, input word_t wd, input bit p,
                      input bit ps, input word_t pd, input bit r,
                      input bit rst);
    bit pop_ok, wr_ok, rd_ok, ps_ok;
    word_t v;
    @(posedge clk);
    #1;
    e_pndng = (tq.size() != 0);
    e_full  = (tq.size() == D);
    e_rxe   = (rq.size() == 0);
    e_err   = err_m;
    e_drop  = drop_m;
    e_mis   = mis_m;
    e_rdv   = rdv_next;
    e_rdd   = rdd_next;
    wr_en = w; wr_data = wd; pop = p;
    push = ps; D_push = pd; rd_en = r; reset = rst;
    if (rst) begin
      tq.delete(); rq.delete();
      drop_m = 0; mis_m = 0; err_m = 0;
      rdv_next = 0; rdd_next = '0;
    end else begin
      pop_ok = p && tq.size() > 0;
      wr_ok  = w && (tq.size() < D || pop_ok);
      if (p && !pop_ok) err_m = 1;
      if (pop_ok) txexp.push_back(tq.pop_front());
      if (wr_ok) tq.push_back(wd);
      rd_ok = r && rq.size() > 0;
      ps_ok = ps && (rq.size() < D || rd_ok);
      if (ps && !ps_ok && drop_m < 255) drop_m++;
      if (ps_ok && pd[31:24] != ID && pd[31:24] != 8'hFF && mis_m < 255)
        mis_m++;
      rdv_next = rd_ok;
      if (rd_ok) begin
        v = rq.pop_front();
        rdexp.push_back(v);
        rdd_next = v;
      end
      if (ps_ok) rq.push_back(pd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0, 0);
  endtask

  function automatic word_t rpkt();
    word_t p;
    int    s;
    p = $urandom;
    s = $urandom_range(0, 3);
    if (s == 0) p[31:24] = ID;
    else if (s == 1) p[31:24] = 8'hFF;
    return p;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pndng", 32'(pndng), 32'(e_pndng));
      chk("tx_full", 32'(tx_full), 32'(e_full));
      chk("rx_empty", 32'(rx_empty), 32'(e_rxe));
      chk("err_pop", 32'(err_pop), 32'(e_err));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      chk("misdir_cnt", 32'(misdir_cnt), 32'(e_mis));
      chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
      chk("rd_data", rd_data, e_rdd);
      if (pop && pndng && !reset) begin
        if (txexp.size() == 0) chk("D_pop_unexpected", 32'(1), 32'(0));
        else chk("D_pop", D_pop, txexp.pop_front());
      end
      if (rd_valid) begin
        if (rdexp.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
        else chk("rd_sb", rd_data, rdexp.pop_front());
      end
    end
  end

  initial begin
    step(0, '0, 0, 0, '0, 0, 1);
    step(0, '0, 0, 0, '0, 0, 1);
    chk_en = 1;
    step(0, '0, 0, 0, '0, 0, 0);

    // Two writes, FWFT pops.
    step(1, 32'h0300_00AA, 0, 0, '0, 0, 0);
    step(1, 32'h0300_00BB, 0, 0, '0, 0, 0);
    idle(1);
    step(0, '0, 1, 0, '0, 0, 0);
    step(0, '0, 1, 0, '0, 0, 0);
    idle(2);

    // Fill TX, reject 17th, then write+pop while full, drain.
    for (int i = 0; i < D; i++) step(1, 32'h0300_1000 + i, 0, 0, '0, 0, 0);
    step(1, 32'hDEAD_0017, 0, 0, '0, 0, 0);
    step(1, 32'h0300_EEEE, 1, 0, '0, 0, 0);
    for (int i = 0; i < D; i++) step(0, '0, 1, 0, '0, 0, 0);
    idle(1);

    // Pop on empty sets sticky err_pop.
    step(0, '0, 1, 0, '0, 0, 0);
    idle(3);

    // RX misdirect check and reads.
    step(0, '0, 0, 1, 32'h0200_0100, 0, 0);
    step(0, '0, 0, 1, 32'hFF00_0101, 0, 0);
    step(0, '0, 0, 1, 32'h0500_0102, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, '0, 1, 0);
    idle(2);
    step(0, '0, 0, 0, '0, 1, 0);
    idle(2);

    // RX overflow, push+read while full, drain plus one empty read.
    for (int i = 0; i < 20; i++) step(0, '0, 0, 1, rpkt(), 0, 0);
    step(0, '0, 0, 1, 32'h0200_ABCD, 1, 0);
    for (int i = 0; i < D + 1; i++) step(0, '0, 0, 0, '0, 1, 0);
    idle(2);

    // Mid-operation reset flushes both FIFOs.
    for (int i = 0; i < 5; i++)
      step(1, 32'h0300_5000 + i, 0, 1, rpkt(), 0, 0);
    step(1, 32'h0300_DEAD, 1, 1, rpkt(), 1, 1);
    idle(1);
    step(1, 32'h0300_0077, 0, 0, '0, 0, 0);
    idle(1);
    step(0, '0, 1, 0, '0, 0, 0);
    idle(2);

    // Randomised traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, rpkt(),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 55, rpkt(),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 299) == 0);
    end
    idle(3);

    chk("txexp_left", 32'(txexp.size()), 32'(0));
    chk("rdexp_left", 32'(rdexp.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
